// File: rtl/cpc_cfg_write_capture.sv
// Purpose : samples the Z80 expansion bus and turns a qualified I/O write to the
//           RAM configuration port (A15=0, D7:D6=11) into a single-cycle strobe.
// Latency : match first present at edge k -> cfg_wr high edges k+QUAL_CYCLES..k+QUAL_CYCLES+1.
// Backpressure: none; the bus cannot be stalled, and each Z80 cycle yields at most one strobe.
//
// Ports:
//   CLK, RESET                 bus clock (rising edge), asynchronous active-high reset
//   IOREQ_B, WR_B, M1_B        Z80 control strobes, active low
//   A15, A14, D[7:0]           address decode bits and data bus
//   cfg_wr                     one-CLK pulse per accepted configuration write
//   cfg_data[5:0]              D5..D0 of the last accepted write
//   cfg_valid                  sticky, set by the first accepted write
//   cfg_count[7:0]             accepted-write counter, saturating at 255
module cpc_cfg_write_capture #(
  parameter int QUAL_CYCLES = 2,
  parameter bit FULL_DECODE = 1'b0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IOREQ_B,
  input  logic       WR_B,
  input  logic       M1_B,
  input  logic       A15,
  input  logic       A14,
  input  logic [7:0] D,
  output logic       cfg_wr,
  output logic [5:0] cfg_data,
  output logic       cfg_valid,
  output logic [7:0] cfg_count
);

  localparam logic [2:0] QUAL_N = 3'(QUAL_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    FIRE = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Input sample stage; every decision below looks only at these registers.
  logic       s1_ioreq_b;
  logic       s1_wr_b;
  logic       s1_m1_b;
  logic       s1_a15;
  logic       s1_a14;
  logic [7:0] s1_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_ioreq_b <= 1'b1;
      s1_wr_b    <= 1'b1;
      s1_m1_b    <= 1'b1;
      s1_a15     <= 1'b0;
      s1_a14     <= 1'b0;
      s1_d       <= 8'h00;
    end else begin
      s1_ioreq_b <= IOREQ_B;
      s1_wr_b    <= WR_B;
      s1_m1_b    <= M1_B;
      s1_a15     <= A15;
      s1_a14     <= A14;
      s1_d       <= D;
    end
  end

  // M1_B low alongside IOREQ_B is interrupt acknowledge, never a port write.
  logic match;
  assign match = !s1_ioreq_b && !s1_wr_b && s1_m1_b && !s1_a15 &&
                 (s1_a14 || !FULL_DECODE) && s1_d[7] && s1_d[6];

  // Bus cycle ends as soon as either strobe is seen released.
  logic bus_end;
  assign bus_end = s1_ioreq_b || s1_wr_b;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] qcnt;
  logic [2:0] qcnt_nxt;

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
      qcnt  <= 3'd0;
    end else begin
      state <= state_nxt;
      qcnt  <= qcnt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    qcnt_nxt  = qcnt;
    case (state)
      IDLE: begin
        if (match) begin
          if (QUAL_N == 3'd1) begin
            state_nxt = FIRE;
            qcnt_nxt  = 3'd0;
          end else begin
            state_nxt = QUAL;
            qcnt_nxt  = 3'd1;
          end
        end
      end
      QUAL: begin
        if (!match) begin
          state_nxt = IDLE;
          qcnt_nxt  = 3'd0;
        end else if (qcnt + 3'd1 == QUAL_N) begin
          state_nxt = FIRE;
          qcnt_nxt  = 3'd0;
        end else begin
          qcnt_nxt  = qcnt + 3'd1;
        end
      end
      FIRE: begin
        state_nxt = HOLD;
      end
      HOLD: begin
        // Matches are ignored here so a long write cannot strobe twice.
        if (bus_end) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        qcnt_nxt  = 3'd0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    cfg_wr = (state == FIRE);
  end

  // Captured configuration, loaded on the edge that enters FIRE so the data of
  // the completing sample is the one kept.
  logic fire_load;
  assign fire_load = (state_nxt == FIRE) && (state != FIRE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cfg_data  <= 6'd0;
      cfg_valid <= 1'b0;
      cfg_count <= 8'd0;
    end else if (fire_load) begin
      cfg_data  <= s1_d[5:0];
      cfg_valid <= 1'b1;
      if (cfg_count != 8'hFF) cfg_count <= cfg_count + 8'd1;
    end
  end

endmodule

// File: doc/cpc_cfg_write_capture.md
# cpc_cfg_write_capture

Front-end stage of the RAM expansion logic: samples the Z80 expansion bus on the CPC clock and recognises I/O writes to the RAM configuration port (A15=0, D7:D6=11). For each qualified bus cycle it delivers exactly one single-cycle write strobe and the registered configuration byte to the downstream block-select register and bank decoder. It replaces the asynchronous NOR-gated write clock with a sampled, glitch-filtered, once-per-cycle event.

## Interface

- QUAL_CYCLES, 2, consecutive matching samples required before firing; legal range 1..7
- FULL_DECODE, 0, 1 = additionally require A14=1 (0x7Fxx decode); 0 = A15-only decode

- CLK  in  1  CPC bus clock, rising-edge active
- RESET  in  1  asynchronous, active-high reset
- IOREQ_B  in  1  Z80 I/O request, active low
- WR_B  in  1  Z80 write strobe, active low
- M1_B  in  1  Z80 M1, active low; IOREQ_B with M1_B low is interrupt acknowledge
- A15  in  1  address bit 15
- A14  in  1  address bit 14
- D  in  8  data bus D7..D0
- cfg_wr  out  1  one-CLK strobe, configuration write accepted
- cfg_data  out  6  D5..D0 of the accepted write, held until the next accepted write
- cfg_valid  out  1  sticky; set by the first accepted write
- cfg_count  out  8  accepted-write counter, saturates at 255

## Operation

- Input stage: IOREQ_B, WR_B, M1_B, A15, A14 and D registered once on every CLK rising edge (s1). All decisions use s1 only.
- match = !IOREQ_B & !WR_B & M1_B & !A15 & (A14 | !FULL_DECODE) & D7 & D6, evaluated on s1.
- FSM states: IDLE, QUAL, FIRE, HOLD. 3-bit qualification counter qcnt.
  - IDLE: match -> QUAL with qcnt=1, or directly to FIRE if QUAL_CYCLES=1. Otherwise stay.
  - QUAL: !match -> IDLE with qcnt=0. match -> qcnt+1. On qcnt+1 == QUAL_CYCLES -> FIRE.
  - FIRE: held for exactly one cycle, then HOLD unconditionally.
  - HOLD: stay while s1 IOREQ_B=0 and s1 WR_B=0. Either one high -> IDLE.
- Entering FIRE loads cfg_data from s1 D[5:0] of the completing sample. It also sets cfg_valid and increments cfg_count, stopping at 255. cfg_wr=1 only while the FSM is in FIRE.
- D changing during QUAL does not abort qualification. Only match does. The last qualifying sample's data wins.
- HOLD ignores any match, including changed data, until the bus cycle ends. This guarantees one strobe per Z80 cycle.
- Interrupt acknowledge (M1_B=0 with IOREQ_B=0) never matches.
- Reads and I/O writes with D7:D6 != 11 never match.

## Timing

- Reset values: cfg_wr=0, cfg_data=0, cfg_valid=0, cfg_count=0, FSM=IDLE, qcnt=0, s1 = all-inactive (IOREQ_B, WR_B, M1_B high; A15, A14, D zero).
- RESET asserted mid-cycle, in any state, clears everything immediately. After release, the FSM re-qualifies from IDLE. An I/O write still in progress at release is accepted if it has QUAL_CYCLES matching samples left.
- Latency: raw match present at edges k .. k+QUAL_CYCLES-1 gives cfg_wr high from edge k+QUAL_CYCLES to edge k+QUAL_CYCLES+1. cfg_data and cfg_count update at edge k+QUAL_CYCLES.
- A match run shorter than QUAL_CYCLES samples produces no strobe and no state change.
- Minimum gap between strobes: bus cycle end seen in s1 (HOLD -> IDLE), then a fresh QUAL_CYCLES run.
- The count saturates: at 255 further accepted writes still pulse cfg_wr and update cfg_data, while cfg_count stays 255.

## Test plan

- Reset then I/O write 0x7F00 with D=0xC5, held 3 samples, QUAL_CYCLES=2 -> one cfg_wr pulse two edges after the first match. cfg_data=0x05, cfg_valid=1, cfg_count=1.
- Write with D=0xC3 held only 1 sample (QUAL_CYCLES=2), and separately a write with D=0x85 -> no cfg_wr. cfg_data, cfg_valid and cfg_count are unchanged.
- IOREQ_B=0, WR_B=0, M1_B=0 (INTACK-like), D=0xFF -> no strobe. Then IOREQ_B and WR_B held low for 10 samples with D switching 0xC1 to 0xC2 after firing -> exactly one pulse, cfg_data=0x01.
- FULL_DECODE=1: write at A15=0, A14=0 with D=0xC7 -> ignored. The same write with A14=1 -> accepted, cfg_data=0x07.
- 256 back-to-back qualified writes -> cfg_count=255, with 256 cfg_wr pulses. The last cfg_data equals the last D[5:0].
- RESET pulsed while in QUAL and while in HOLD -> all outputs 0 asynchronously. A write that resumes after release with 2 matching samples -> accepted.
